// File: rtl/jt12_pg_pkg.sv
// Shared constants and slot/operator index helpers for the JT12 phase-generator controller.
package jt12_pg_pkg;
    localparam int SLOTS   = 24;
    localparam int NCH     = 6;
    localparam int SLOT_W  = 5;
    localparam int CH_W    = 3;
    localparam int OP_W    = 2;
    localparam int DT1_DLY = 1;
    localparam int RST_DLY = 2;
    localparam int MUL_DLY = 4;

    typedef enum logic [1:0] {
        SEL_FNUM = 2'd0,
        SEL_MUL  = 2'd1,
        SEL_KEY  = 2'd2,
        SEL_CH3  = 2'd3
    } wr_sel_e;

    // Slot groups run S1, S3, S2, S4; the swap is its own inverse, so one table maps both ways.
    localparam logic [OP_W-1:0] GRP_OP [4] = '{2'd0, 2'd2, 2'd1, 2'd3};

    function automatic logic [OP_W-1:0] slot_grp(input logic [SLOT_W-1:0] s);
        if (s >= 5'd18)      return 2'd3;
        else if (s >= 5'd12) return 2'd2;
        else if (s >= 5'd6)  return 2'd1;
        else                 return 2'd0;
    endfunction

    function automatic logic [CH_W-1:0] slot_ch(input logic [SLOT_W-1:0] s);
        return CH_W'(s - SLOT_W'(slot_grp(s)) * 5'd6);
    endfunction

    function automatic logic [SLOT_W-1:0] slot_of(input logic [CH_W-1:0] ch,
                                                  input logic [OP_W-1:0] op);
        return SLOT_W'(GRP_OP[op]) * 5'd6 + SLOT_W'(ch);
    endfunction
endpackage

// File: rtl/jt12_pg_ctrl_if.sv
// Register-write bus from the write decoder into the phase-generator controller.
interface jt12_pg_ctrl_if;
    logic        wr_en;
    logic [1:0]  wr_sel;
    logic [2:0]  wr_ch;
    logic [1:0]  wr_op;
    logic [13:0] wr_data;
    logic        wr_xfn;

    modport master (output wr_en, wr_sel, wr_ch, wr_op, wr_data, wr_xfn);
    modport slave  (input  wr_en, wr_sel, wr_ch, wr_op, wr_data, wr_xfn);
endinterface

// File: rtl/jt12_pg_dly.sv
// Fixed-length delay line with asynchronous clear, used to align values to later pipeline stages.
module jt12_pg_dly #(
    parameter int W      = 1,
    parameter int STAGES = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    logic [W-1:0] pipe_q [STAGES];
    logic [W-1:0] pipe_d [STAGES];

    always_comb begin
        pipe_d[0] = din;
        for (int i = 1; i < STAGES; i++) pipe_d[i] = pipe_q[i-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign dout = pipe_q[STAGES-1];
endmodule

// File: rtl/jt12_pg_ctrl.sv
// Slot sequencer and parameter scheduler for the JT12 phase generator: runs the 24-slot
// multiplex, holds frequency/mul/dt1/key state and presents each value at its consuming stage.
module jt12_pg_ctrl
    import jt12_pg_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    jt12_pg_ctrl_if.slave     wr,
    input  logic              halt,
    output logic [10:0]       fnum_I,
    output logic [2:0]        block_I,
    output logic [2:0]        dt1_II,
    output logic [3:0]        mul_V,
    output logic              pg_rst_III,
    output logic              pg_stop,
    output logic              zero,
    output logic [SLOT_W-1:0] slot_I
);
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              zero_q, zero_d;
    logic [13:0]       freq_q, freq_d;
    logic [6:0]        opp_q, opp_d;
    logic              rst_q, rst_d;
    logic              stop_q, stop_d;
    logic              ch3_q, ch3_d;
    logic [13:0]       chf_q [NCH], chf_d [NCH];
    logic [13:0]       xf_q [3], xf_d [3];
    logic [6:0]        opr_q [SLOTS], opr_d [SLOTS];
    logic [SLOTS-1:0]  key_q, key_d, pend_q, pend_d;
    logic [CH_W-1:0]   rd_ch;
    logic [OP_W-1:0]   rd_op;
    logic              wr_ok;
    logic [SLOT_W-1:0] wr_slot;

    // Stage I registers are loaded with the slot about to be presented (slot_d).
    always_comb begin
        slot_d = (slot_q == SLOT_W'(SLOTS - 1)) ? '0 : slot_q + SLOT_W'(1);
        zero_d = (slot_d == '0);
        rd_ch  = slot_ch(slot_d);
        rd_op  = GRP_OP[slot_grp(slot_d)];
        if (ch3_q && rd_ch == 3'd2 && rd_op != 2'd3) freq_d = xf_q[rd_op];
        else                                         freq_d = chf_q[rd_ch];
        opp_d  = opr_q[slot_d];
        rst_d  = pend_q[slot_d];
        stop_d = halt;

        ch3_d  = ch3_q;
        chf_d  = chf_q;
        xf_d   = xf_q;
        opr_d  = opr_q;
        key_d  = key_q;
        pend_d = pend_q;
        pend_d[slot_d] = 1'b0;

        wr_ok   = wr.wr_en && (wr.wr_ch < CH_W'(NCH));
        wr_slot = slot_of(wr.wr_ch, wr.wr_op);
        if (wr_ok) begin
            case (wr_sel_e'(wr.wr_sel))
                SEL_FNUM: begin
                    if (wr.wr_xfn && wr.wr_ch == 3'd2 && wr.wr_op != 2'd3)
                        xf_d[wr.wr_op] = wr.wr_data;
                    else
                        chf_d[wr.wr_ch] = wr.wr_data;
                end
                SEL_MUL: opr_d[wr_slot] = wr.wr_data[6:0];
                SEL_KEY: begin
                    // Setting after the read-clear above makes a new key edge win over the clear.
                    for (int i = 0; i < 4; i++) begin
                        key_d[slot_of(wr.wr_ch, OP_W'(i))] = wr.wr_data[i];
                        if (wr.wr_data[i] && !key_q[slot_of(wr.wr_ch, OP_W'(i))])
                            pend_d[slot_of(wr.wr_ch, OP_W'(i))] = 1'b1;
                    end
                end
                default: ch3_d = wr.wr_data[0];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
            zero_q <= 1'b1;
            freq_q <= '0;
            opp_q  <= '0;
            rst_q  <= 1'b0;
            stop_q <= 1'b0;
            ch3_q  <= 1'b0;
            key_q  <= '0;
            pend_q <= '0;
            for (int i = 0; i < NCH; i++)   chf_q[i] <= '0;
            for (int i = 0; i < 3; i++)     xf_q[i]  <= '0;
            for (int i = 0; i < SLOTS; i++) opr_q[i] <= '0;
        end else begin
            slot_q <= slot_d;
            zero_q <= zero_d;
            freq_q <= freq_d;
            opp_q  <= opp_d;
            rst_q  <= rst_d;
            stop_q <= stop_d;
            ch3_q  <= ch3_d;
            key_q  <= key_d;
            pend_q <= pend_d;
            chf_q  <= chf_d;
            xf_q   <= xf_d;
            opr_q  <= opr_d;
        end
    end

    assign slot_I  = slot_q;
    assign zero    = zero_q;
    assign fnum_I  = freq_q[10:0];
    assign block_I = freq_q[13:11];
    assign pg_stop = stop_q;

    jt12_pg_dly #(.W(3), .STAGES(DT1_DLY)) u_dt1_dly (
        .clk(clk), .rst_n(rst_n), .din(opp_q[6:4]), .dout(dt1_II)
    );
    jt12_pg_dly #(.W(1), .STAGES(RST_DLY)) u_rst_dly (
        .clk(clk), .rst_n(rst_n), .din(rst_q), .dout(pg_rst_III)
    );
    jt12_pg_dly #(.W(4), .STAGES(MUL_DLY)) u_mul_dly (
        .clk(clk), .rst_n(rst_n), .din(opp_q[3:0]), .dout(mul_V)
    );
endmodule

// File: tb/tb_jt12_pg_ctrl.sv
// Self-checking bench for jt12_pg_ctrl: vector table for frequency routing plus a cycle-indexed
// scoreboard for slot sequencing, stage offsets, key-on phase resets and mid-frame reset.
module tb_jt12_pg_ctrl;
    import jt12_pg_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        halt;
    logic [10:0] fnum_I;
    logic [2:0]  block_I;
    logic [2:0]  dt1_II;
    logic [3:0]  mul_V;
    logic        pg_rst_III;
    logic        pg_stop;
    logic        zero;
    logic [4:0]  slot_I;

    jt12_pg_ctrl_if wr_if ();

    jt12_pg_ctrl dut (
        .clk(clk), .rst_n(rst_n), .wr(wr_if), .halt(halt),
        .fnum_I(fnum_I), .block_I(block_I), .dt1_II(dt1_II), .mul_V(mul_V),
        .pg_rst_III(pg_rst_III), .pg_stop(pg_stop), .zero(zero), .slot_I(slot_I)
    );

    always #5 clk = ~clk;

    // Bench-side cycle index: 0 is the first cycle after reset release.
    int cyc = 0;
    always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct { int due; int sig; int val; } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic        en;
        logic [1:0]  sel;
        logic [2:0]  ch;
        logic [1:0]  op;
        logic        xfn;
        logic [13:0] data;
        int          slot;
        int          fnum;
        int          blk;
    } vec_t;
    vec_t vecs[14];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int obs(input int sig);
        case (sig)
            0: return int'(fnum_I);
            1: return int'(block_I);
            2: return int'(mul_V);
            3: return int'(dt1_II);
            4: return int'(pg_rst_III);
            5: return int'(pg_stop);
            6: return int'(slot_I);
            default: return int'(zero);
        endcase
    endfunction

    function automatic string sig_name(input int sig);
        case (sig)
            0: return "fnum_I";
            1: return "block_I";
            2: return "mul_V";
            3: return "dt1_II";
            4: return "pg_rst_III";
            5: return "pg_stop";
            6: return "slot_I";
            default: return "zero";
        endcase
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n) begin
            while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                e = sb_q.pop_front();
                if (e.due != cyc) chk("sb_stale_due", e.due, cyc);
                else              chk(sig_name(e.sig), obs(e.sig), e.val);
            end
        end
    end

    task automatic push(input int due, input int sig, input int val);
        sb_q.push_back('{due, sig, val});
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb_q.size() > 0; i++) tick(1);
        chk("sb_drain", sb_q.size(), 0);
    endtask

    task automatic align(input int m);
        for (int i = 0; i < 30 && (cyc % 24) != m; i++) tick(1);
    endtask

    function automatic int next_at(input int from, input int s);
        int t = from;
        while ((t % 24) != s) t++;
        return t;
    endfunction

    task automatic do_wr(input logic [1:0] sel, input logic [2:0] ch, input logic [1:0] op,
                         input logic xfn, input logic [13:0] data, output int c);
        wr_if.wr_en   = 1'b1;
        wr_if.wr_sel  = sel;
        wr_if.wr_ch   = ch;
        wr_if.wr_op   = op;
        wr_if.wr_xfn  = xfn;
        wr_if.wr_data = data;
        c = cyc;
        tick(1);
        wr_if.wr_en  = 1'b0;
        wr_if.wr_xfn = 1'b0;
    endtask

    // A slot whose read (one cycle before presentation) follows the write pulses two cycles later.
    task automatic key_test(input logic [2:0] ch, input logic [3:0] mask, input logic [23:0] exp_slots);
        int c;
        do_wr(SEL_KEY, ch, 2'd0, 1'b0, {10'd0, mask}, c);
        for (int d = c + 1; d <= c + 30; d++) begin
            int t = d - 2;
            push(d, 4, (t >= c + 2 && t <= c + 25 && exp_slots[t % 24]) ? 1 : 0);
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, t, last_c;

        rst_n = 1'b0;
        halt  = 1'b0;
        wr_if.wr_en   = 1'b0;
        wr_if.wr_sel  = 2'd0;
        wr_if.wr_ch   = 3'd0;
        wr_if.wr_op   = 2'd0;
        wr_if.wr_xfn  = 1'b0;
        wr_if.wr_data = 14'd0;

        vecs[0]  = '{1'b1, 2'd0, 3'd1, 2'd0, 1'b0, {3'd5, 11'h2A5}, 1,  'h2A5, 5};
        vecs[1]  = '{1'b0, 2'd0, 3'd0, 2'd0, 1'b0, 14'd0,            7,  'h2A5, 5};
        vecs[2]  = '{1'b0, 2'd0, 3'd0, 2'd0, 1'b0, 14'd0,            13, 'h2A5, 5};
        vecs[3]  = '{1'b0, 2'd0, 3'd0, 2'd0, 1'b0, 14'd0,            19, 'h2A5, 5};
        vecs[4]  = '{1'b0, 2'd0, 3'd0, 2'd0, 1'b0, 14'd0,            0,  0,     0};
        vecs[5]  = '{1'b0, 2'd0, 3'd0, 2'd0, 1'b0, 14'd0,            4,  0,     0};
        vecs[6]  = '{1'b1, 2'd3, 3'd0, 2'd0, 1'b0, 14'd1,            2,  0,     0};
        vecs[7]  = '{1'b1, 2'd0, 3'd2, 2'd0, 1'b1, {3'd3, 11'h100},  2,  'h100, 3};
        vecs[8]  = '{1'b1, 2'd0, 3'd2, 2'd1, 1'b1, {3'd0, 11'h200},  14, 'h200, 0};
        vecs[9]  = '{1'b1, 2'd0, 3'd2, 2'd2, 1'b1, {3'd0, 11'h300},  8,  'h300, 0};
        vecs[10] = '{1'b1, 2'd0, 3'd2, 2'd0, 1'b0, {3'd1, 11'h400},  20, 'h400, 1};
        vecs[11] = '{1'b0, 2'd0, 3'd0, 2'd0, 1'b0, 14'd0,            2,  'h100, 3};
        vecs[12] = '{1'b1, 2'd3, 3'd0, 2'd0, 1'b0, 14'd0,            2,  'h400, 1};
        vecs[13] = '{1'b0, 2'd0, 3'd0, 2'd0, 1'b0, 14'd0,            14, 'h400, 1};

        // Reset state, then two full frames of sequencing with empty registers.
        tick(3);
        chk("rst_slot_I", int'(slot_I), 0);
        chk("rst_zero", int'(zero), 1);
        chk("rst_fnum_I", int'(fnum_I), 0);
        chk("rst_pg_rst_III", int'(pg_rst_III), 0);
        rst_n = 1'b1;
        for (int d = 0; d < 48; d++) begin
            push(d, 6, d % 24);
            push(d, 7, (d % 24 == 0) ? 1 : 0);
            push(d, 0, 0);
            push(d, 1, 0);
            push(d, 2, 0);
            push(d, 3, 0);
            push(d, 4, 0);
            push(d, 5, 0);
        end
        drain();

        // Frequency routing, including ch3 extra registers.
        last_c = cyc;
        foreach (vecs[i]) begin
            if (vecs[i].en)
                do_wr(vecs[i].sel, vecs[i].ch, vecs[i].op, vecs[i].xfn, vecs[i].data, last_c);
            t = next_at((last_c + 2 > cyc) ? last_c + 2 : cyc, vecs[i].slot);
            push(t, 0, vecs[i].fnum);
            push(t, 1, vecs[i].blk);
            drain();
        end

        // MUL/DT1 stage offsets for ch4 S4 (slot 22).
        do_wr(SEL_MUL, 3'd4, 2'd3, 1'b0, {7'd0, 3'd5, 4'd7}, c);
        t = next_at(c + 2, 22);
        push(t,     3, 0);
        push(t + 1, 3, 5);
        push(t + 2, 3, 0);
        push(t + 3, 2, 0);
        push(t + 4, 2, 7);
        push(t + 5, 2, 0);
        drain();

        // Out-of-range channel must not alias onto slot 6.
        do_wr(SEL_MUL, 3'd6, 2'd0, 1'b0, 14'h7F, c);
        t = next_at(c + 2, 6);
        push(t + 1, 3, 0);
        push(t + 4, 2, 0);
        drain();

        // Key-on phase resets.
        key_test(3'd0, 4'hF, 24'h041041);
        key_test(3'd0, 4'hF, 24'h000000);
        key_test(3'd0, 4'h0, 24'h000000);
        align(23);
        key_test(3'd0, 4'h1, 24'h000001);

        align(10);
        do_wr(SEL_KEY, 3'd1, 2'd0, 1'b0, 14'h1, c);
        key_test(3'd1, 4'h0, 24'h000002);

        align(10);
        do_wr(SEL_KEY, 3'd3, 2'd0, 1'b0, 14'h1, c);
        do_wr(SEL_KEY, 3'd3, 2'd0, 1'b0, 14'h0, c);
        key_test(3'd3, 4'h1, 24'h000008);

        key_test(3'd6, 4'hF, 24'h000000);

        // Mid-frame reset with a pending key-on for slot 23.
        align(0);
        halt = 1'b1;
        push(cyc, 5, 0);
        push(cyc + 1, 5, 1);
        do_wr(SEL_FNUM, 3'd5, 2'd0, 1'b0, {3'd2, 11'h155}, c);
        do_wr(SEL_MUL, 3'd4, 2'd2, 1'b0, {7'd0, 3'd6, 4'd9}, c);
        do_wr(SEL_KEY, 3'd5, 2'd0, 1'b0, 14'h8, c);
        drain();
        align(11);
        chk("pre_rst_slot_I", int'(slot_I), 11);
        chk("pre_rst_fnum_I", int'(fnum_I), 'h155);
        chk("pre_rst_block_I", int'(block_I), 2);
        chk("pre_rst_dt1_II", int'(dt1_II), 6);
        chk("pre_rst_pg_stop", int'(pg_stop), 1);
        halt = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_slot_I", int'(slot_I), 0);
        chk("mid_rst_zero", int'(zero), 1);
        chk("mid_rst_fnum_I", int'(fnum_I), 0);
        chk("mid_rst_block_I", int'(block_I), 0);
        chk("mid_rst_dt1_II", int'(dt1_II), 0);
        chk("mid_rst_mul_V", int'(mul_V), 0);
        chk("mid_rst_pg_stop", int'(pg_stop), 0);
        chk("mid_rst_pg_rst_III", int'(pg_rst_III), 0);
        tick(2);
        rst_n = 1'b1;
        for (int d = 0; d < 30; d++) begin
            push(d, 6, d % 24);
            push(d, 4, 0);
            if (d == 11) begin
                push(d, 0, 0);
                push(d, 3, 0);
            end
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
